// File: rtl/qubit_gate_sequencer.sv
// Queues single-qubit gate opcodes and applies each to an external Qubit_State register in Q8.8.
// Define QGATE_T_GATE_EN to make opcode 6 (T) legal; otherwise it is rejected with illegal_op.
module qubit_gate_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 16,
    parameter int FRAC_W     = 8,
    parameter int INV_SQRT2  = 181,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          op_valid,
    input  logic [2:0]                    op_code,
    output logic                          op_ready,
    input  logic signed [DATA_W-1:0]      cur_alpha_re,
    input  logic signed [DATA_W-1:0]      cur_alpha_im,
    input  logic signed [DATA_W-1:0]      cur_beta_re,
    input  logic signed [DATA_W-1:0]      cur_beta_im,
    output logic signed [DATA_W-1:0]      new_alpha_re,
    output logic signed [DATA_W-1:0]      new_alpha_im,
    output logic signed [DATA_W-1:0]      new_beta_re,
    output logic signed [DATA_W-1:0]      new_beta_im,
    output logic                          update_en,
    output logic                          busy,
    output logic                          gate_done,
    output logic                          illegal_op,
    output logic [CNT_W-1:0]              gate_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int PW = 2 * DATA_W + 2;
    localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);
    localparam logic signed [PW-1:0] SAT_MAX = {{(PW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = {{(PW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic signed [PW-1:0] COEF = PW'(INV_SQRT2);
    localparam logic signed [DATA_W-1:0] ONE = DATA_W'(1 << FRAC_W);

    localparam logic [2:0] OP_X = 3'd1, OP_Y = 3'd2, OP_Z = 3'd3, OP_H = 3'd4;
    localparam logic [2:0] OP_S = 3'd5, OP_T = 3'd6, OP_ZERO = 3'd7;

    typedef enum logic [1:0] {IDLE, LOAD, EXEC, COMMIT} state_t;
    state_t state;

    logic [2:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push, pop;

    logic [2:0]               op_p0;
    logic signed [DATA_W-1:0] ar_p0, ai_p0, br_p0, bi_p0;
    logic signed [DATA_W-1:0] nxt_ar, nxt_ai, nxt_br, nxt_bi;
    logic                     illegal;

    function automatic logic signed [DATA_W:0] ext1(input logic signed [DATA_W-1:0] x);
        return {x[DATA_W-1], x};
    endfunction

    function automatic logic signed [PW-1:0] ext_w(input logic signed [DATA_W:0] x);
        return {{(PW-DATA_W-1){x[DATA_W]}}, x};
    endfunction

    function automatic logic signed [DATA_W-1:0] sat(input logic signed [PW-1:0] x);
        if (x > SAT_MAX) return SAT_MAX[DATA_W-1:0];
        else if (x < SAT_MIN) return SAT_MIN[DATA_W-1:0];
        else return x[DATA_W-1:0];
    endfunction

    function automatic logic signed [DATA_W-1:0] neg_sat(input logic signed [DATA_W-1:0] x);
        return sat(-ext_w(ext1(x)));
    endfunction

    function automatic logic signed [DATA_W:0] add1(input logic signed [DATA_W-1:0] a,
                                                    input logic signed [DATA_W-1:0] b);
        return ext1(a) + ext1(b);
    endfunction

    function automatic logic signed [DATA_W:0] sub1(input logic signed [DATA_W-1:0] a,
                                                    input logic signed [DATA_W-1:0] b);
        return ext1(a) - ext1(b);
    endfunction

    // Full-width product by 1/sqrt2, floor shift back to Q8.8, then saturate.
    function automatic logic signed [DATA_W-1:0] scale(input logic signed [DATA_W:0] s);
        logic signed [PW-1:0] prod;
        prod = ext_w(s) * COEF;
        return sat(prod >>> FRAC_W);
    endfunction

    assign push     = op_valid && op_ready;
    assign pop      = (state == IDLE) && (fifo_level != '0);
    assign op_ready = (fifo_level != FULL);
    assign busy     = (state != IDLE) || (fifo_level != '0);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= op_code;
    end

    // Stage p0: popped opcode and the amplitudes captured in LOAD.
    always_ff @(posedge clk) begin
        if (pop) op_p0 <= mem[rd_ptr];
        if (state == LOAD) begin
            ar_p0 <= cur_alpha_re;
            ai_p0 <= cur_alpha_im;
            br_p0 <= cur_beta_re;
            bi_p0 <= cur_beta_im;
        end
    end

    always_comb begin
        nxt_ar  = ar_p0;
        nxt_ai  = ai_p0;
        nxt_br  = br_p0;
        nxt_bi  = bi_p0;
        illegal = 1'b0;
        case (op_p0)
            OP_X: begin
                nxt_ar = br_p0;  nxt_ai = bi_p0;
                nxt_br = ar_p0;  nxt_bi = ai_p0;
            end
            OP_Y: begin
                nxt_ar = bi_p0;           nxt_ai = neg_sat(br_p0);
                nxt_br = neg_sat(ai_p0);  nxt_bi = ar_p0;
            end
            OP_Z: begin
                nxt_br = neg_sat(br_p0);  nxt_bi = neg_sat(bi_p0);
            end
            OP_H: begin
                nxt_ar = scale(add1(ar_p0, br_p0));  nxt_ai = scale(add1(ai_p0, bi_p0));
                nxt_br = scale(sub1(ar_p0, br_p0));  nxt_bi = scale(sub1(ai_p0, bi_p0));
            end
            OP_S: begin
                nxt_br = neg_sat(bi_p0);  nxt_bi = br_p0;
            end
            OP_T: begin
`ifdef QGATE_T_GATE_EN
                nxt_br = scale(sub1(br_p0, bi_p0));
                nxt_bi = scale(add1(br_p0, bi_p0));
`else
                illegal = 1'b1;
`endif
            end
            OP_ZERO: begin
                nxt_ar = ONE;  nxt_ai = '0;
                nxt_br = '0;   nxt_bi = '0;
            end
            default: ;
        endcase
    end

    // Stage p1: queue control, FSM and the registered commit outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_level   <= '0;
            new_alpha_re <= '0;
            new_alpha_im <= '0;
            new_beta_re  <= '0;
            new_beta_im  <= '0;
            update_en    <= 1'b0;
            gate_done    <= 1'b0;
            illegal_op   <= 1'b0;
            gate_count   <= '0;
        end else begin
            update_en  <= 1'b0;
            gate_done  <= 1'b0;
            illegal_op <= 1'b0;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      fifo_level <= fifo_level + LW'(1);
            else if (pop && !push) fifo_level <= fifo_level - LW'(1);
            case (state)
                IDLE:   if (pop) state <= LOAD;
                LOAD:   state <= EXEC;
                EXEC: begin
                    if (illegal) begin
                        illegal_op <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        new_alpha_re <= nxt_ar;
                        new_alpha_im <= nxt_ai;
                        new_beta_re  <= nxt_br;
                        new_beta_im  <= nxt_bi;
                        update_en    <= 1'b1;
                        gate_done    <= 1'b1;
                        state        <= COMMIT;
                    end
                end
                COMMIT: begin
                    gate_count <= gate_count + CNT_W'(1);
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
